csr_file: RTL and testbench

//  Control/status register file answering the WB-stage CSR port: combinational reads, masked writes,

---
 rtl/csr_file.sv | 200 ++++++++++++++++++++
 tb/tb_csr_file.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// CSR file beside the WB stage: combinational reads, masked writes,
// exception entry / ertn return state, interrupt status and the stable timer.
module csr_file #(
    parameter logic [31:0] CORE_ID = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic        ertn_flush,
    input  logic [31:0] wb_pc,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] era_out,
    output logic        has_int
);

    localparam int unsigned NUM_W  = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IS_W   = 13;
    localparam int unsigned VA_W   = 26;

    localparam logic [NUM_W-1:0] CSR_CRMD   = 14'h000;
    localparam logic [NUM_W-1:0] CSR_PRMD   = 14'h001;
    localparam logic [NUM_W-1:0] CSR_ECFG   = 14'h004;
    localparam logic [NUM_W-1:0] CSR_ESTAT  = 14'h005;
    localparam logic [NUM_W-1:0] CSR_ERA    = 14'h006;
    localparam logic [NUM_W-1:0] CSR_EENTRY = 14'h00C;
    localparam logic [NUM_W-1:0] CSR_SAVE0  = 14'h030;
    localparam logic [NUM_W-1:0] CSR_SAVE1  = 14'h031;
    localparam logic [NUM_W-1:0] CSR_SAVE2  = 14'h032;
    localparam logic [NUM_W-1:0] CSR_SAVE3  = 14'h033;
    localparam logic [NUM_W-1:0] CSR_TID    = 14'h040;
    localparam logic [NUM_W-1:0] CSR_TCFG   = 14'h041;
    localparam logic [NUM_W-1:0] CSR_TVAL   = 14'h042;
    localparam logic [NUM_W-1:0] CSR_TICLR  = 14'h044;

    // ECFG.LIE bit 10 is reserved and never holds a 1
    localparam logic [IS_W-1:0]   LIE_MASK  = 13'h1BFF;
    localparam logic [DATA_W-1:0] TVAL_PARK = 32'hFFFF_FFFF;
    localparam logic [3:0]        CRMD_RST  = 4'b1000;

    // architectural state
    logic [3:0]              crmd_q,  crmd_nxt;    // {DA,IE,PLV[1:0]}
    logic [2:0]              prmd_q,  prmd_nxt;    // {PIE,PPLV[1:0]}
    logic [IS_W-1:0]         lie_q,   lie_nxt;
    logic [IS_W-1:0]         is_q,    is_nxt;
    logic [5:0]              ecode_q, ecode_nxt;
    logic [8:0]              esub_q,  esub_nxt;
    logic [DATA_W-1:0]       era_q,   era_nxt;
    logic [VA_W-1:0]         eva_q,   eva_nxt;
    logic [3:0][DATA_W-1:0]  save_q,  save_nxt;
    logic [DATA_W-1:0]       tid_q,   tid_nxt;
    logic [DATA_W-1:0]       tcfg_q,  tcfg_nxt;    // {InitVal[31:2],Periodic,En}
    logic [DATA_W-1:0]       tval_q,  tval_nxt;

    logic [DATA_W-1:0] csr_img_c;
    logic [DATA_W-1:0] wr_new_c;
    logic              wr_en_c;
    logic              tcfg_wr_c;
    logic              ticlr_c;
    logic              timer_fire_c;

    // field image of the addressed CSR, also the base for masked writes
    always_comb begin
        csr_img_c = '0;
        case (csr_num)
            CSR_CRMD:   csr_img_c = {28'b0, crmd_q};
            CSR_PRMD:   csr_img_c = {29'b0, prmd_q};
            CSR_ECFG:   csr_img_c = {19'b0, lie_q};
            CSR_ESTAT:  csr_img_c = {1'b0, esub_q, ecode_q, 3'b0, is_q};
            CSR_ERA:    csr_img_c = era_q;
            CSR_EENTRY: csr_img_c = {eva_q, 6'b0};
            CSR_SAVE0:  csr_img_c = save_q[0];
            CSR_SAVE1:  csr_img_c = save_q[1];
            CSR_SAVE2:  csr_img_c = save_q[2];
            CSR_SAVE3:  csr_img_c = save_q[3];
            CSR_TID:    csr_img_c = tid_q;
            CSR_TCFG:   csr_img_c = tcfg_q;
            CSR_TVAL:   csr_img_c = tval_q;
            default:    csr_img_c = '0;
        endcase
    end

    // write qualifiers shared by the next-state logic
    always_comb begin
        wr_en_c      = csr_we & ~wb_ex;
        wr_new_c     = (csr_img_c & ~csr_wmask) | (csr_wvalue & csr_wmask);
        tcfg_wr_c    = wr_en_c && (csr_num == CSR_TCFG);
        ticlr_c      = wr_en_c && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];
        timer_fire_c = tcfg_q[0] && (tval_q == '0);
    end

    // next-state: software write, then timer / interrupt sampling, then exception or ertn
    always_comb begin
        crmd_nxt  = crmd_q;
        prmd_nxt  = prmd_q;
        lie_nxt   = lie_q;
        is_nxt    = is_q;
        ecode_nxt = ecode_q;
        esub_nxt  = esub_q;
        era_nxt   = era_q;
        eva_nxt   = eva_q;
        save_nxt  = save_q;
        tid_nxt   = tid_q;
        tcfg_nxt  = tcfg_q;
        tval_nxt  = tval_q;

        if (wr_en_c) begin
            case (csr_num)
                CSR_CRMD:   crmd_nxt    = wr_new_c[3:0];
                CSR_PRMD:   prmd_nxt    = wr_new_c[2:0];
                CSR_ECFG:   lie_nxt     = wr_new_c[IS_W-1:0] & LIE_MASK;
                CSR_ESTAT:  is_nxt[1:0] = wr_new_c[1:0];
                CSR_ERA:    era_nxt     = wr_new_c;
                CSR_EENTRY: eva_nxt     = wr_new_c[31:6];
                CSR_SAVE0,
                CSR_SAVE1,
                CSR_SAVE2,
                CSR_SAVE3:  save_nxt[csr_num[1:0]] = wr_new_c;
                CSR_TID:    tid_nxt     = wr_new_c;
                CSR_TCFG:   tcfg_nxt    = wr_new_c;
                default:    ;
            endcase
        end

        // a TCFG write reloads the counter and beats any decrement or reload
        if (tcfg_wr_c) begin
            tval_nxt = {wr_new_c[31:2], 2'b00};
        end else if (tcfg_q[0]) begin
            if (tval_q == '0) begin
                tval_nxt = tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : TVAL_PARK;
            end else if (tcfg_q[1] || (tval_q != TVAL_PARK)) begin
                tval_nxt = tval_q - 32'd1;
            end
        end

        // level-sampled interrupt lines; timer bit is sticky until TICLR
        is_nxt[9:2] = hw_int_in;
        is_nxt[10]  = 1'b0;
        is_nxt[11]  = (is_q[11] | timer_fire_c) & ~ticlr_c;
        is_nxt[12]  = ipi_int_in;

        if (wb_ex) begin
            prmd_nxt    = crmd_q[2:0];
            crmd_nxt    = {crmd_q[3], 3'b000};
            era_nxt     = wb_pc;
            ecode_nxt   = wb_ecode;
            esub_nxt    = wb_esubcode;
        end else if (ertn_flush) begin
            crmd_nxt[2:0] = prmd_q;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_q  <= CRMD_RST;
            prmd_q  <= '0;
            lie_q   <= '0;
            is_q    <= '0;
            ecode_q <= '0;
            esub_q  <= '0;
            era_q   <= '0;
            eva_q   <= '0;
            save_q  <= '0;
            tid_q   <= CORE_ID;
            tcfg_q  <= '0;
            tval_q  <= '0;
        end else begin
            crmd_q  <= crmd_nxt;
            prmd_q  <= prmd_nxt;
            lie_q   <= lie_nxt;
            is_q    <= is_nxt;
            ecode_q <= ecode_nxt;
            esub_q  <= esub_nxt;
            era_q   <= era_nxt;
            eva_q   <= eva_nxt;
            save_q  <= save_nxt;
            tid_q   <= tid_nxt;
            tcfg_q  <= tcfg_nxt;
            tval_q  <= tval_nxt;
        end
    end

    // outputs taken straight from the registered state
    assign csr_rvalue = csr_re ? csr_img_c : '0;
    assign ex_entry   = {eva_q, 6'b0};
    assign era_out    = era_q;
    assign has_int    = crmd_q[2] & (|(is_q & lie_q));

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a register-image model.
module tb_csr_file;

    localparam logic [31:0] CORE_ID = 32'h0000_0005;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        csr_re = 1'b0;
    logic [13:0] csr_num = '0;
    logic [31:0] csr_rvalue;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wmask = '0;
    logic [31:0] csr_wvalue = '0;
    logic        wb_ex = 1'b0;
    logic        ertn_flush = 1'b0;
    logic [31:0] wb_pc = '0;
    logic [5:0]  wb_ecode = '0;
    logic [8:0]  wb_esubcode = '0;
    logic [7:0]  hw_int_in = '0;
    logic        ipi_int_in = 1'b0;
    logic [31:0] ex_entry;
    logic [31:0] era_out;
    logic        has_int;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    csr_file #(.CORE_ID(CORE_ID)) dut (
        .clk(clk), .resetn(resetn),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_pc(wb_pc),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .ex_entry(ex_entry), .era_out(era_out), .has_int(has_int)
    );

    always #5 clk = ~clk;

    // model: one 32-bit image per CSR as software would see it
    logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_eentry, m_tid, m_tcfg, m_tval;
    logic [31:0] m_save [4];

    function automatic logic [31:0] wmask_of(input logic [13:0] n);
        case (n)
            14'h000: return 32'h0000_000F;
            14'h001: return 32'h0000_0007;
            14'h004: return 32'h0000_1BFF;
            14'h005: return 32'h0000_0003;
            14'h006: return 32'hFFFF_FFFF;
            14'h00C: return 32'hFFFF_FFC0;
            14'h030, 14'h031, 14'h032, 14'h033: return 32'hFFFF_FFFF;
            14'h040: return 32'hFFFF_FFFF;
            14'h041: return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] n);
        case (n)
            14'h000: return m_crmd;
            14'h001: return m_prmd;
            14'h004: return m_ecfg;
            14'h005: return m_estat;
            14'h006: return m_era;
            14'h00C: return m_eentry;
            14'h030: return m_save[0];
            14'h031: return m_save[1];
            14'h032: return m_save[2];
            14'h033: return m_save[3];
            14'h040: return m_tid;
            14'h041: return m_tcfg;
            14'h042: return m_tval;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_has_int();
        return m_crmd[2] & (|(m_estat[12:0] & m_ecfg[12:0]));
    endfunction

    task automatic model_reset();
        m_crmd = 32'h8; m_prmd = '0; m_ecfg = '0; m_estat = '0; m_era = '0;
        m_eentry = '0; m_tid = CORE_ID; m_tcfg = '0; m_tval = '0;
        for (int i = 0; i < 4; i++) m_save[i] = '0;
    endtask

    task automatic model_step();
        logic [31:0] o_crmd, o_prmd, o_tcfg, o_tval, msk, img;
        logic wr, fire;
        o_crmd = m_crmd; o_prmd = m_prmd; o_tcfg = m_tcfg; o_tval = m_tval;
        wr = csr_we && !wb_ex;
        if (wr) begin
            msk = csr_wmask & wmask_of(csr_num);
            img = (m_read(csr_num) & ~msk) | (csr_wvalue & msk);
            case (csr_num)
                14'h000: m_crmd = img;
                14'h001: m_prmd = img;
                14'h004: m_ecfg = img;
                14'h005: m_estat = img;
                14'h006: m_era = img;
                14'h00C: m_eentry = img;
                14'h030: m_save[0] = img;
                14'h031: m_save[1] = img;
                14'h032: m_save[2] = img;
                14'h033: m_save[3] = img;
                14'h040: m_tid = img;
                14'h041: begin m_tcfg = img; m_tval = img & 32'hFFFF_FFFC; end
                default: ;
            endcase
        end
        fire = o_tcfg[0] && (o_tval == 32'h0);
        if (o_tcfg[0] && !(wr && csr_num == 14'h041)) begin
            if (o_tval == 32'h0)
                m_tval = o_tcfg[1] ? (o_tcfg & 32'hFFFF_FFFC) : 32'hFFFF_FFFF;
            else if (o_tcfg[1] || o_tval != 32'hFFFF_FFFF)
                m_tval = o_tval - 32'd1;
        end
        m_estat[9:2] = hw_int_in;
        m_estat[10]  = 1'b0;
        m_estat[12]  = ipi_int_in;
        if (fire) m_estat[11] = 1'b1;
        if (wr && csr_num == 14'h044 && csr_wmask[0] && csr_wvalue[0]) m_estat[11] = 1'b0;
        if (wb_ex) begin
            m_prmd = {29'b0, o_crmd[2:0]};
            m_crmd[2:0] = 3'b000;
            m_era = wb_pc;
            m_estat[21:16] = wb_ecode;
            m_estat[30:22] = wb_esubcode;
        end else if (ertn_flush) begin
            m_crmd[2:0] = o_prmd[2:0];
        end
    endtask

    always @(posedge clk) if (resetn) model_step();
    always @(negedge resetn) model_reset();

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("rvalue", csr_rvalue, csr_re ? m_read(csr_num) : 32'h0);
            check("ex_entry", ex_entry, m_eentry);
            check("era_out", era_out, m_era);
            check("has_int", 32'(has_int), 32'(m_has_int()));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] n, input logic [31:0] v, input logic [31:0] m);
        csr_num = n; csr_wvalue = v; csr_wmask = m; csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [13:0] n, input logic [31:0] exp);
        csr_num = n; csr_re = 1'b1;
        #1;
        check(name, csr_rvalue, exp);
    endtask

    task automatic bit_chk(input string name, input logic [13:0] n, input int b, input logic exp);
        csr_num = n; csr_re = 1'b1;
        #1;
        check(name, 32'(csr_rvalue[b]), 32'(exp));
    endtask

    function automatic logic [13:0] pick_num(input int k);
        case (k)
            0: return 14'h000;  1: return 14'h001;  2: return 14'h004;  3: return 14'h005;
            4: return 14'h006;  5: return 14'h00C;  6: return 14'h030;  7: return 14'h031;
            8: return 14'h032;  9: return 14'h033; 10: return 14'h040; 11: return 14'h041;
           12: return 14'h042; 13: return 14'h044; 14: return 14'h002;
            default: return 14'($urandom);
        endcase
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        resetn = 1'b1;
        chk_en = 1'b1;

        // reset values
        rd_chk("rst_crmd", 14'h000, 32'h0000_0008);
        rd_chk("rst_tid", 14'h040, CORE_ID);
        rd_chk("rst_tval", 14'h042, 32'h0);
        check("rst_has_int", 32'(has_int), 32'h0);
        check("rst_era", era_out, 32'h0);

        // masked writes, reserved bits, unlisted index
        wr(14'h031, 32'hDEAD_BEEF, 32'h0000_FFFF);
        rd_chk("save1_masked", 14'h031, 32'h0000_BEEF);
        check("model_save1", m_save[1], 32'h0000_BEEF);
        wr(14'h031, 32'h1234_5678, 32'h0);
        rd_chk("save1_mask0", 14'h031, 32'h0000_BEEF);
        wr(14'h00C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("eentry_low0", ex_entry, 32'hFFFF_FFC0);
        wr(14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_chk("ecfg_bit10", 14'h004, 32'h0000_1BFF);
        wr(14'h004, 32'h0, 32'hFFFF_FFFF);
        wr(14'h002, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_chk("unlisted", 14'h002, 32'h0);
        rd_chk("ticlr_rd", 14'h044, 32'h0);

        // exception entry and return
        wr(14'h000, 32'h7, 32'h7);
        rd_chk("crmd_plv3ie", 14'h000, 32'h0000_000F);
        wb_ex = 1'b1; wb_pc = 32'h1C00_0100; wb_ecode = 6'h0B; wb_esubcode = 9'h0;
        tick();
        wb_ex = 1'b0;
        rd_chk("ex_crmd", 14'h000, 32'h0000_0008);
        rd_chk("ex_prmd", 14'h001, 32'h0000_0007);
        check("model_prmd", m_prmd, 32'h0000_0007);
        rd_chk("ex_era", 14'h006, 32'h1C00_0100);
        check("ex_era_out", era_out, 32'h1C00_0100);
        csr_num = 14'h005; #1;
        check("ex_ecode", 32'(csr_rvalue[21:16]), 32'h0B);
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        rd_chk("ertn_crmd", 14'h000, 32'h0000_000F);

        // interrupt enable path
        wr(14'h004, 32'h4, 32'hFFFF_FFFF);
        hw_int_in = 8'h01;
        tick();
        bit_chk("is2", 14'h005, 2, 1'b1);
        check("has_int_on", 32'(has_int), 32'h1);
        wr(14'h000, 32'h0, 32'h4);
        check("has_int_ie0", 32'(has_int), 32'h0);
        hw_int_in = 8'h00;
        tick();

        // periodic timer
        wr(14'h041, 32'h0000_0013, 32'hFFFF_FFFF);
        rd_chk("tval_load", 14'h042, 32'h10);
        repeat (16) tick();
        rd_chk("tval_zero", 14'h042, 32'h0);
        bit_chk("is11_before", 14'h005, 11, 1'b0);
        tick();
        bit_chk("is11_fire", 14'h005, 11, 1'b1);
        rd_chk("tval_reload", 14'h042, 32'h10);
        wr(14'h044, 32'h1, 32'h1);
        bit_chk("is11_clr", 14'h005, 11, 1'b0);

        // one-shot timer
        wr(14'h041, 32'h0000_0011, 32'hFFFF_FFFF);
        repeat (17) tick();
        rd_chk("oneshot_park", 14'h042, 32'hFFFF_FFFF);
        bit_chk("oneshot_fire", 14'h005, 11, 1'b1);
        wr(14'h044, 32'h1, 32'h1);
        repeat (20) tick();
        rd_chk("oneshot_hold", 14'h042, 32'hFFFF_FFFF);
        bit_chk("oneshot_single", 14'h005, 11, 1'b0);
        wr(14'h041, 32'h0, 32'hFFFF_FFFF);

        // exception beats both a CSR write and ertn in the same cycle
        wr(14'h030, 32'h55, 32'hFFFF_FFFF);
        csr_num = 14'h030; csr_wvalue = 32'hAAAA; csr_wmask = 32'hFFFF_FFFF; csr_we = 1'b1;
        wb_ex = 1'b1; ertn_flush = 1'b1; wb_pc = 32'h1C00_0200; wb_ecode = 6'h03;
        tick();
        csr_we = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
        rd_chk("ex_save0", 14'h030, 32'h55);
        rd_chk("ex2_era", 14'h006, 32'h1C00_0200);
        rd_chk("ex2_crmd", 14'h000, 32'h0000_0008);
        rd_chk("ex2_prmd", 14'h001, 32'h0000_0003);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            csr_re     = ($urandom_range(0, 3) != 0);
            csr_num    = pick_num(int'($urandom_range(0, 15)));
            csr_we     = ($urandom_range(0, 99) < 40);
            csr_wvalue = $urandom;
            csr_wmask  = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom;
            if (csr_num == 14'h041) csr_wvalue = 32'($urandom_range(0, 127));
            wb_ex       = ($urandom_range(0, 29) == 0);
            ertn_flush  = ($urandom_range(0, 19) == 0);
            wb_pc       = $urandom;
            wb_ecode    = 6'($urandom);
            wb_esubcode = 9'($urandom);
            if ($urandom_range(0, 7) == 0) hw_int_in = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ipi_int_in = 1'($urandom);
            tick();
        end
        csr_we = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
        tick();

        // asynchronous reset mid-operation
        resetn = 1'b0;
        rd_chk("arst_crmd", 14'h000, 32'h0000_0008);
        rd_chk("arst_tval", 14'h042, 32'h0);
        check("arst_has_int", 32'(has_int), 32'h0);
        @(negedge clk); #1;
        resetn = 1'b1;
        repeat (4) tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
